// File: rtl/poly_audio_engine.sv
// Multi-voice tone generator: phase-accumulator voices (square/saw/noise) with
// linearly decaying envelopes, summed into a first-order sigma-delta bitstream.
module poly_audio_engine #(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 16,
  parameter int LEVEL_W    = 4,
  parameter int VSEL_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
  parameter int SUM_W      = LEVEL_W + $clog2(NUM_VOICES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               env_tick,
  input  logic               cfg_we,
  input  logic [VSEL_W-1:0]  cfg_voice,
  input  logic               cfg_sel,
  input  logic [PHASE_W-1:0] cfg_data,
  output logic [SUM_W-1:0]   mix_out,
  output logic               audio
);

  localparam logic [1:0] MODE_SQUARE = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;
  localparam logic [1:0] MODE_NOISE  = 2'd2;

  logic [PHASE_W-1:0]   phase     [NUM_VOICES];
  logic [PHASE_W-1:0]   inc       [NUM_VOICES];
  logic [PHASE_W-1:0]   phase_nxt [NUM_VOICES];
  logic                 wrap      [NUM_VOICES];
  logic [LEVEL_W-1:0]   env_level [NUM_VOICES];
  logic [LEVEL_W-1:0]   sample    [NUM_VOICES];
  logic [2*LEVEL_W-1:0] saw_prod  [NUM_VOICES];
  logic [1:0]           mode      [NUM_VOICES];
  logic                 gate      [NUM_VOICES];
  logic                 decay_en  [NUM_VOICES];
  logic [15:0]          lfsr      [NUM_VOICES];
  logic [NUM_VOICES-1:0] wr_hit;
  logic [SUM_W-1:0]     sd_acc;
  logic [SUM_W-1:0]     mix_sum;

  logic [LEVEL_W-1:0] ctrl_level;
  logic [1:0]         ctrl_mode;
  logic               ctrl_decay_en;
  logic               ctrl_gate;

  assign ctrl_level    = cfg_data[LEVEL_W-1:0];
  assign ctrl_mode     = cfg_data[LEVEL_W+1:LEVEL_W];
  assign ctrl_decay_en = cfg_data[LEVEL_W+2];
  assign ctrl_gate     = cfg_data[LEVEL_W+3];

  // Out-of-range voice indices match no decode line, so those writes drop.
  always_comb begin
    wr_hit = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      wr_hit[v] = cfg_we && (cfg_voice == VSEL_W'(v));
    end
  end

  always_comb begin
    mix_sum = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      {wrap[v], phase_nxt[v]} = {1'b0, phase[v]} + {1'b0, inc[v]};
      saw_prod[v] = phase[v][PHASE_W-1 -: LEVEL_W] * env_level[v];
      case (mode[v])
        MODE_SQUARE: sample[v] = phase[v][PHASE_W-1] ? env_level[v] : '0;
        MODE_SAW:    sample[v] = saw_prod[v][2*LEVEL_W-1:LEVEL_W];
        MODE_NOISE:  sample[v] = lfsr[v][0] ? env_level[v] : '0;
        default:     sample[v] = '0;
      endcase
      mix_sum = mix_sum + SUM_W'(sample[v]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase[v]     <= '0;
        inc[v]       <= '0;
        env_level[v] <= '0;
        mode[v]      <= MODE_SQUARE;
        gate[v]      <= 1'b0;
        decay_en[v]  <= 1'b0;
        lfsr[v]      <= 16'hACE1 + 16'(v);
      end
      mix_out <= '0;
      sd_acc  <= '0;
      audio   <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase[v] <= phase_nxt[v];
        if (wrap[v]) begin
          lfsr[v] <= {lfsr[v][14:0], lfsr[v][15] ^ lfsr[v][13] ^ lfsr[v][12] ^ lfsr[v][10]};
        end
        if (wr_hit[v] && !cfg_sel) begin
          inc[v] <= cfg_data;
        end
        // A control write takes priority over a same-cycle envelope tick.
        if (wr_hit[v] && cfg_sel) begin
          mode[v]      <= ctrl_mode;
          decay_en[v]  <= ctrl_decay_en;
          gate[v]      <= ctrl_gate;
          env_level[v] <= ctrl_gate ? ctrl_level : '0;
        end else if (env_tick && decay_en[v] && gate[v] && (env_level[v] != '0)) begin
          env_level[v] <= env_level[v] - 1'b1;
        end
      end
      mix_out           <= mix_sum;
      {audio, sd_acc}   <= {1'b0, sd_acc} + {1'b0, mix_out};
    end
  end

endmodule

// File: tb/tb_poly_audio_engine.sv
// Randomised and directed bench for poly_audio_engine, checked every cycle
// against an arithmetic model of voices, mixer and sigma-delta.
module tb_poly_audio_engine;

  localparam int NV = 4;
  localparam int PW = 16;
  localparam int LW = 4;
  localparam int SW = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        env_tick = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_voice = '0;
  logic [2:0]  cfg_voice5 = 3'd7;
  logic        cfg_sel = 1'b0;
  logic [15:0] cfg_data = '0;
  logic [5:0]  mix_out;
  logic        audio;
  logic [6:0]  mix5;
  logic        audio5;

  int errors = 0;
  int checks = 0;
  bit inv5 = 1'b1;

  poly_audio_engine dut (
    .clk(clk), .rst(rst), .env_tick(env_tick), .cfg_we(cfg_we),
    .cfg_voice(cfg_voice), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .mix_out(mix_out), .audio(audio)
  );

  // Five-voice instance: indices 5..7 are addressable but must be ignored.
  poly_audio_engine #(.NUM_VOICES(5)) dut5 (
    .clk(clk), .rst(rst), .env_tick(env_tick), .cfg_we(cfg_we),
    .cfg_voice(cfg_voice5), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .mix_out(mix5), .audio(audio5)
  );

  always #5 clk = ~clk;

  int m_phase [NV];
  int m_inc   [NV];
  int m_lvl   [NV];
  int m_mode  [NV];
  int m_dec   [NV];
  int m_lfsr  [NV];
  int m_mix = 0;
  int m_sd = 0;
  int m_audio = 0;

  function automatic int lfsr_next(input int l);
    int fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l * 2) % 65536) + fb;
  endfunction

  function automatic int voice_sample(input int v);
    case (m_mode[v])
      0: return (m_phase[v] >= (1 << (PW - 1))) ? m_lvl[v] : 0;
      1: return ((m_phase[v] >> (PW - LW)) * m_lvl[v]) / (1 << LW);
      2: return (m_lfsr[v] % 2 == 1) ? m_lvl[v] : 0;
      default: return 0;
    endcase
  endfunction

  // Model advances on each rising edge from the inputs held since the last falling edge.
  initial begin
    int t;
    int d;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int v = 0; v < NV; v++) begin
          m_phase[v] = 0; m_inc[v] = 0; m_lvl[v] = 0; m_mode[v] = 0; m_dec[v] = 0;
          m_lfsr[v] = 16'hACE1 + v;
        end
        m_mix = 0; m_sd = 0; m_audio = 0;
      end else begin
        t = m_sd + m_mix;
        m_audio = (t >= (1 << SW)) ? 1 : 0;
        m_sd = t % (1 << SW);
        m_mix = 0;
        for (int v = 0; v < NV; v++) m_mix += voice_sample(v);
        d = int'(cfg_data);
        for (int v = 0; v < NV; v++) begin
          t = m_phase[v] + m_inc[v];
          if (t >= (1 << PW)) m_lfsr[v] = lfsr_next(m_lfsr[v]);
          m_phase[v] = t % (1 << PW);
          if (cfg_we && int'(cfg_voice) == v && !cfg_sel) m_inc[v] = d;
          if (cfg_we && int'(cfg_voice) == v && cfg_sel) begin
            m_mode[v] = (d / 16) % 4;
            m_dec[v]  = (d / 64) % 2;
            m_lvl[v]  = ((d / 128) % 2 == 1) ? d % 16 : 0;
          end else if (env_tick && m_dec[v] == 1 && m_lvl[v] > 0) begin
            m_lvl[v] = m_lvl[v] - 1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [15:0] ctrl(input int g, input int dc, input int m, input int l);
    logic [15:0] w;
    w = 16'(g % 2) * 16'd128 + 16'(dc % 2) * 16'd64 + 16'(m % 4) * 16'd16 + 16'(l % 16);
    return w;
  endfunction

  task automatic wr(input int v, input bit sel, input logic [15:0] d, input bit tick);
    cfg_we = 1'b1; cfg_voice = 2'(v); cfg_sel = sel; cfg_data = d; env_tick = tick;
    @(negedge clk);
    cfg_we = 1'b0; env_tick = 1'b0;
  endtask

  task automatic pulse_tick();
    env_tick = 1'b1;
    @(negedge clk);
    env_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cfg_we = 1'b1; cfg_voice = 2'(i); cfg_sel = i[0]; cfg_data = 16'hFFFF; env_tick = 1'b1;
      @(negedge clk);
    end
    rst = 1'b0; cfg_we = 1'b0; env_tick = 1'b0; cfg_data = '0;
  endtask

  task automatic observe(input int n, output int mn, output int mx, output int nz, output int ones);
    mn = 1 << 30; mx = -1; nz = 0; ones = 0;
    repeat (n) begin
      @(negedge clk);
      if (int'(mix_out) < mn) mn = int'(mix_out);
      if (int'(mix_out) > mx) mx = int'(mix_out);
      if (mix_out != 0) nz++;
      if (audio) ones++;
    end
  endtask

  initial begin
    int mn, mx, nz, ones;
    int peaks [5] = '{3, 2, 1, 0, 0};

    fork
      forever begin
        @(negedge clk);
        chk("mix_out_vs_model", int'(mix_out), m_mix);
        chk("audio_vs_model", int'(audio), m_audio);
        if (inv5) begin
          chk("bad_voice_mix", int'(mix5), 0);
          chk("bad_voice_audio", int'(audio5), 0);
        end
      end
    join_none

    @(negedge clk);
    do_reset();
    observe(8, mn, mx, nz, ones);
    chk("reset_mix_max", mx, 0);
    chk("reset_audio_ones", ones, 0);

    // Square on voice 0
    wr(0, 1'b0, 16'h0800, 1'b0);
    wr(0, 1'b1, ctrl(1, 0, 0, 15), 1'b0);
    repeat (4) @(negedge clk);
    observe(64, mn, mx, nz, ones);
    chk("square_max", mx, 15);
    chk("square_min", mn, 0);
    chk("square_high_cycles", nz, 32);
    observe(1024, mn, mx, nz, ones);
    chk_rng("square_audio_ones", ones, 119, 121);

    // All four voices at full scale
    do_reset();
    for (int v = 0; v < NV; v++) wr(v, 1'b1, ctrl(1, 0, 0, 15), 1'b0);
    for (int v = 0; v < NV; v++) wr(v, 1'b0, 16'h0800, 1'b0);
    repeat (4) @(negedge clk);
    observe(64, mn, mx, nz, ones);
    chk("fullscale_max", mx, 60);
    chk("fullscale_min", mn, 0);

    // Decay to zero, then hold with decay disabled
    do_reset();
    wr(1, 1'b0, 16'h0800, 1'b0);
    wr(1, 1'b1, ctrl(1, 1, 0, 3), 1'b0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      observe(40, mn, mx, nz, ones);
      chk($sformatf("decay_peak_%0d", i), mx, peaks[i]);
      pulse_tick();
    end
    wr(1, 1'b1, ctrl(1, 0, 0, 3), 1'b0);
    pulse_tick();
    pulse_tick();
    observe(40, mn, mx, nz, ones);
    chk("no_decay_peak", mx, 3);

    // Control write colliding with env_tick
    do_reset();
    wr(1, 1'b1, ctrl(1, 1, 0, 2), 1'b0);
    wr(2, 1'b1, ctrl(1, 1, 0, 5), 1'b0);
    wr(1, 1'b0, 16'h0800, 1'b0);
    wr(2, 1'b0, 16'h0800, 1'b0);
    wr(1, 1'b1, ctrl(1, 1, 0, 9), 1'b1);
    repeat (2) @(negedge clk);
    observe(64, mn, mx, nz, ones);
    chk("collision_peak", mx, 13);

    // Noise voice
    do_reset();
    wr(3, 1'b1, ctrl(1, 0, 2, 15), 1'b0);
    wr(3, 1'b0, 16'h8000, 1'b0);
    observe(128, mn, mx, nz, ones);
    chk("noise_max", mx, 15);
    chk("noise_min", mn, 0);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 199) == 0);
      cfg_we     = ($urandom_range(0, 9) < 3);
      cfg_voice  = 2'($urandom_range(0, 3));
      cfg_sel    = 1'($urandom_range(0, 1));
      cfg_data   = 16'($urandom);
      env_tick   = ($urandom_range(0, 19) == 0);
      cfg_voice5 = 3'($urandom_range(5, 7));
      @(negedge clk);
    end
    rst = 1'b0; cfg_we = 1'b0; env_tick = 1'b0;

    // Highest valid index on the five-voice instance does respond
    do_reset();
    inv5 = 1'b0;
    cfg_voice5 = 3'd4;
    wr(0, 1'b0, 16'h0800, 1'b0);
    wr(0, 1'b1, ctrl(1, 0, 0, 15), 1'b0);
    cfg_voice5 = 3'd7;
    mx = 0;
    repeat (64) begin
      @(negedge clk);
      if (int'(mix5) > mx) mx = int'(mix5);
    end
    chk("voice4_peak", mx, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
